// File: rtl/noekeon_gamma_serial.sv
// Serial NOEKEON Gamma: the 32 bit-slice S-box columns are substituted LANES at a
// time, so a 128-bit block takes 32/LANES cycles in RUN before it is presented.
module noekeon_gamma_serial #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         inValid,
    output logic         inReady,
    input  logic [127:0] inData,
    output logic         outValid,
    input  logic         outReady,
    output logic [127:0] outData,
    output logic         busy
);

    localparam int N  = 32 / LANES;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 ||
              LANES == 16 || LANES == 32)) begin : g_bad_lanes
            $error("noekeon_gamma_serial: LANES must be 1, 2, 4, 8, 16 or 32");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    state_t          next_state;
    logic [CW-1:0]   counter;
    logic [127:0]    stateReg;
    logic [127:0]    sub_state;
    logic            accept;
    logic            last_slice;
    logic [4:0]      lane_col [LANES];
    logic [3:0]      lane_out [LANES];

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h7;
            4'h1: y = 4'hA;
            4'h2: y = 4'h2;
            4'h3: y = 4'hC;
            4'h4: y = 4'h4;
            4'h5: y = 4'h8;
            4'h6: y = 4'hF;
            4'h7: y = 4'h0;
            4'h8: y = 4'h5;
            4'h9: y = 4'h9;
            4'hA: y = 4'h1;
            4'hB: y = 4'hE;
            4'hC: y = 4'h3;
            4'hD: y = 4'hD;
            4'hE: y = 4'hB;
            default: y = 4'h6;
        endcase
        return y;
    endfunction

    // One S-box per lane, reading the column chosen by the current slice.
    for (genvar j = 0; j < LANES; j++) begin : g_lane
        logic [3:0] nib_in;
        assign lane_col[j] = 5'(int'(counter) * LANES + j);
        assign nib_in = {stateReg[{2'd3, lane_col[j]}], stateReg[{2'd2, lane_col[j]}],
                         stateReg[{2'd1, lane_col[j]}], stateReg[{2'd0, lane_col[j]}]};
        assign lane_out[j] = sbox(nib_in);
    end

    // Columns outside the active slice pass through untouched.
    for (genvar c = 0; c < 32; c++) begin : g_col
        localparam int LANE  = c % LANES;
        localparam int SLICE = c / LANES;
        logic hit;
        assign hit = (counter == CW'(SLICE));
        assign sub_state[96 + c] = hit ? lane_out[LANE][3] : stateReg[96 + c];
        assign sub_state[64 + c] = hit ? lane_out[LANE][2] : stateReg[64 + c];
        assign sub_state[32 + c] = hit ? lane_out[LANE][1] : stateReg[32 + c];
        assign sub_state[c]      = hit ? lane_out[LANE][0] : stateReg[c];
    end

    assign last_slice = (counter == CW'(N - 1));
    assign accept     = inValid & inReady;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (clear) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) next_state = RUN;
                RUN:     if (last_slice) next_state = DONE;
                DONE:    if (outReady) next_state = inValid ? RUN : IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        inReady  = !clear && ((state == IDLE) || ((state == DONE) && outReady));
        outValid = (state == DONE);
        busy     = (state == RUN);
        outData  = stateReg;
    end

    // Clear only rewinds the counter; the partially substituted block is left in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter  <= '0;
            stateReg <= '0;
        end else if (clear) begin
            counter <= '0;
        end else if (accept) begin
            counter  <= '0;
            stateReg <= inData;
        end else if (state == RUN) begin
            stateReg <= sub_state;
            counter  <= last_slice ? '0 : counter + 1'b1;
        end
    end

endmodule

// File: tb/tb_noekeon_gamma_serial.sv
// Self-checking bench for noekeon_gamma_serial: a LANES=4 instance driven by directed and
// random traffic against a column-wise Gamma model, plus a LANES=32 back-to-back instance.
module tb_noekeon_gamma_serial;

    localparam int LANES = 4;
    localparam int N     = 32 / LANES;

    logic         clk;
    logic         rst_n;
    logic         clear;
    logic         inValid;
    logic         inReady;
    logic [127:0] inData;
    logic         outValid;
    logic         outReady;
    logic [127:0] outData;
    logic         busy;

    logic         b_clear;
    logic         b_inValid;
    logic         b_inReady;
    logic [127:0] b_inData;
    logic         b_outValid;
    logic         b_outReady;
    logic [127:0] b_outData;
    logic         b_busy;

    int           vectors;
    int           miscompares;
    logic         m_have;
    int           m_remain;
    logic [127:0] m_exp;
    int           accepted;
    int           delivered;

    noekeon_gamma_serial #(.LANES(LANES)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .inValid(inValid), .inReady(inReady), .inData(inData),
        .outValid(outValid), .outReady(outReady), .outData(outData),
        .busy(busy)
    );

    noekeon_gamma_serial #(.LANES(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .clear(b_clear),
        .inValid(b_inValid), .inReady(b_inReady), .inData(b_inData),
        .outValid(b_outValid), .outReady(b_outReady), .outData(b_outData),
        .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] gamma(input logic [127:0] x);
        logic [63:0]  tbl;
        logic [127:0] y;
        logic [3:0]   s;
        int           nib;
        tbl = 64'h7A2C48F0591E3DB6;
        y   = '0;
        for (int i = 0; i < 32; i++) begin
            nib = 8 * int'(x[96 + i]) + 4 * int'(x[64 + i]) + 2 * int'(x[32 + i]) + int'(x[i]);
            s   = tbl[60 - 4 * nib +: 4];
            y[96 + i] = s[3];
            y[64 + i] = s[2];
            y[32 + i] = s[1];
            y[i]      = s[0];
        end
        return y;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
            $error("[TB] %s miscompare", tag);
        end
    endtask

    // One cycle: drive inputs, check outputs against the protocol model, advance the model.
    task automatic applyStimulus(input logic iv, input logic [127:0] d,
                                 input logic ordy, input logic clr);
        logic exp_valid;
        logic exp_ready;
        logic exp_busy;
        inValid  = iv;
        inData   = d;
        outReady = ordy;
        clear    = clr;
        #1;
        exp_valid = m_have && (m_remain == 0);
        exp_busy  = m_have && (m_remain > 0);
        exp_ready = !clr && (!m_have || (exp_valid && ordy));
        checkOutput("inReady", 128'(inReady), 128'(exp_ready));
        checkOutput("outValid", 128'(outValid), 128'(exp_valid));
        checkOutput("busy", 128'(busy), 128'(exp_busy));
        if (exp_valid) checkOutput("outData", outData, m_exp);
        if (clr) begin
            m_have = 1'b0;
        end else begin
            if (exp_valid && ordy) begin
                m_have = 1'b0;
                delivered++;
            end
            if (iv && exp_ready) begin
                m_have   = 1'b1;
                m_remain = N;
                m_exp    = gamma(d);
                accepted++;
            end else if (m_have && m_remain > 0) begin
                m_remain--;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulseReset(input string tag);
        rst_n = 1'b0;
        #1;
        checkOutput({tag, " outData"}, outData, 128'h0);
        checkOutput({tag, " outValid"}, 128'(outValid), 128'h0);
        checkOutput({tag, " busy"}, 128'(busy), 128'h0);
        checkOutput({tag, " inReady"}, 128'(inReady), 128'h1);
        m_have = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [127:0] x;
        logic [127:0] y;
        logic [127:0] prev;
        int           cycles;

        vectors = 0; miscompares = 0; accepted = 0; delivered = 0;
        m_have = 1'b0; m_remain = 0; m_exp = '0;
        clear = 1'b0; inValid = 1'b0; inData = '0; outReady = 1'b0;
        b_clear = 1'b0; b_inValid = 1'b0; b_inData = '0; b_outReady = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset outData", outData, 128'h0);
        checkOutput("reset inReady", 128'(inReady), 128'h1);
        checkOutput("reset outValid", 128'(outValid), 128'h0);
        checkOutput("reset busy", 128'(busy), 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // All-zero block: latency N and the known all-zero result.
        applyStimulus(1'b1, 128'h0, 1'b1, 1'b0);
        repeat (N) applyStimulus(1'b0, 128'h0, 1'b0, 1'b0);
        checkOutput("zero block", outData, 128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF);
        applyStimulus(1'b0, 128'h0, 1'b1, 1'b0);

        // Involution: Gamma applied twice restores the block.
        x = 128'h0123456789ABCDEF_FEDCBA9876543210;
        applyStimulus(1'b1, x, 1'b0, 1'b0);
        repeat (N) applyStimulus(1'b1, rand128(), 1'b0, 1'b0);
        y = outData;
        applyStimulus(1'b1, y, 1'b1, 1'b0);
        repeat (N) applyStimulus(1'b0, 128'h0, 1'b0, 1'b0);
        checkOutput("involution", outData, x);
        applyStimulus(1'b0, 128'h0, 1'b1, 1'b0);

        // Backpressure for 10 cycles in DONE, with new blocks offered and refused.
        applyStimulus(1'b1, rand128(), 1'b0, 1'b0);
        repeat (N) applyStimulus(1'b0, 128'h0, 1'b0, 1'b0);
        prev = outData;
        repeat (10) applyStimulus(1'b1, rand128(), 1'b0, 1'b0);
        checkOutput("held outData", outData, prev);
        applyStimulus(1'b0, 128'h0, 1'b1, 1'b0);

        // Clear on the 3rd RUN edge while a new block is also offered.
        applyStimulus(1'b1, rand128(), 1'b1, 1'b0);
        applyStimulus(1'b0, 128'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 128'h0, 1'b1, 1'b0);
        applyStimulus(1'b1, rand128(), 1'b1, 1'b1);
        repeat (N + 2) applyStimulus(1'b0, 128'h0, 1'b1, 1'b0);
        applyStimulus(1'b1, rand128(), 1'b1, 1'b0);
        repeat (N + 1) applyStimulus(1'b0, 128'h0, 1'b1, 1'b0);

        // Reset mid-RUN and in DONE, each followed by a clean block.
        applyStimulus(1'b1, rand128(), 1'b1, 1'b0);
        repeat (3) applyStimulus(1'b0, 128'h0, 1'b1, 1'b0);
        pulseReset("rst run");
        repeat (N + 2) applyStimulus(1'b0, 128'h0, 1'b1, 1'b0);
        applyStimulus(1'b1, rand128(), 1'b0, 1'b0);
        repeat (N + 1) applyStimulus(1'b0, 128'h0, 1'b0, 1'b0);
        pulseReset("rst done");
        applyStimulus(1'b0, 128'h0, 1'b1, 1'b0);
        applyStimulus(1'b1, rand128(), 1'b1, 1'b0);
        repeat (N + 1) applyStimulus(1'b0, 128'h0, 1'b1, 1'b0);

        // Random traffic with gaps on both sides.
        delivered = 0;
        cycles    = 0;
        while (delivered < 1000 && cycles < 40000) begin
            applyStimulus($urandom_range(0, 3) != 0, rand128(), $urandom_range(0, 3) != 0, 1'b0);
            cycles++;
        end
        if (delivered < 1000) begin
            miscompares++;
            $display("[TB] FAIL random timeout delivered=%0d required=1000", delivered);
        end
        applyStimulus(1'b0, 128'h0, 1'b1, 1'b0);
        repeat (N + 1) applyStimulus(1'b0, 128'h0, 1'b1, 1'b0);

        // LANES=32: inValid held high gives one result every two cycles.
        b_outReady = 1'b1;
        b_inValid  = 1'b1;
        prev       = '0;
        for (int k = 0; k < 8; k++) begin
            x        = rand128();
            b_inData = x;
            #1;
            checkOutput("b2b inReady done", 128'(b_inReady), 128'h1);
            checkOutput("b2b outValid done", 128'(b_outValid), 128'(k > 0));
            if (k > 0) checkOutput("b2b outData", b_outData, gamma(prev));
            prev = x;
            @(posedge clk);
            #1;
            b_inData = rand128();
            #1;
            checkOutput("b2b busy", 128'(b_busy), 128'h1);
            checkOutput("b2b inReady run", 128'(b_inReady), 128'h0);
            checkOutput("b2b outValid run", 128'(b_outValid), 128'h0);
            @(posedge clk);
            #1;
        end
        b_inValid = 1'b0;
        #1;
        checkOutput("b2b last outData", b_outData, gamma(prev));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
